// File: rtl/instr_fetch_queue_if.sv
// Handshake bundle between the fetch unit, instruction memory, the fetch queue and decode.
// The slave side is the queue itself; the master side is everything around it.
interface instr_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            i_pc_valid;
    logic [XLEN-1:0] i_pc_data;
    logic            o_pc_ready;
    logic            o_im_ren;
    logic [XLEN-1:0] o_im_raddr;
    logic [ILEN-1:0] i_im_rdata;
    logic            i_flush;
    logic            o_id_valid;
    logic            i_id_ready;
    logic [ILEN-1:0] o_id_instr;
    logic [XLEN-1:0] o_id_pc;
    logic [CW-1:0]   o_count;

    modport slave (
        input  i_pc_valid, i_pc_data, i_im_rdata, i_flush, i_id_ready,
        output o_pc_ready, o_im_ren, o_im_raddr, o_id_valid, o_id_instr, o_id_pc, o_count
    );

    modport master (
        output i_pc_valid, i_pc_data, i_im_rdata, i_flush, i_id_ready,
        input  o_pc_ready, o_im_ren, o_im_raddr, o_id_valid, o_id_instr, o_id_pc, o_count
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch queue: issues one instruction-memory read per accepted PC, captures the word one
// cycle later together with its PC, and presents entries in order to decode.
module instr_fetch_queue #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rstn,
    instr_fetch_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] pc_inflight_q, pc_inflight_d;

    logic [ILEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];

    logic          pc_ready;
    logic          acc;
    logic          capture;
    logic          id_valid;
    logic          deq;
    logic [CW:0]   occupancy;

    // Slots already promised to an in-flight read count as occupied, and a same-cycle
    // dequeue is deliberately ignored so ready never depends on decode's ready.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign pc_ready  = rstn & ~bus.i_flush & (occupancy < (CW + 1)'(DEPTH));
    assign acc       = bus.i_pc_valid & pc_ready;
    assign capture   = inflight_q & ~bus.i_flush;
    assign id_valid  = (count_q != '0);
    assign deq       = id_valid & bus.i_id_ready;

    assign bus.o_pc_ready = pc_ready;
    assign bus.o_im_ren   = acc;
    assign bus.o_im_raddr = bus.i_pc_data;
    assign bus.o_id_valid = id_valid;
    assign bus.o_count    = count_q;
    assign bus.o_id_instr = id_valid ? instr_mem[rd_ptr_q] : '0;
    assign bus.o_id_pc    = id_valid ? pc_mem[rd_ptr_q]    : '0;

    always_comb begin
        // NOTE: every variable gets a default first so no path through this block can infer a latch.
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        inflight_d    = acc;
        pc_inflight_d = acc ? bus.i_pc_data : pc_inflight_q;

        if (bus.i_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            inflight_d = 1'b0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(capture);
            rd_ptr_d = rd_ptr_q + PW'(deq);
            count_d  = count_q + CW'(capture) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            pc_inflight_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            pc_inflight_q <= pc_inflight_d;
        end
    end

    // NOTE: storage is not reset; an empty queue masks the head to zero, so stale words never leak.
    always_ff @(posedge clk) begin
        if (capture) begin
            instr_mem[wr_ptr_q] <= bus.i_im_rdata;
            pc_mem[wr_ptr_q]    <= pc_inflight_q;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed and random checks of instr_fetch_queue against an in-order scoreboard.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_instr_fetch_queue;
    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    instr_fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

    instr_fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_errors = 0;
    int              acc_seen = 0;
    entry_t          model_q[$];
    logic            pend_v   = 1'b0;
    logic [XLEN-1:0] pend_pc  = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents seen by the bench.
    function automatic logic [ILEN-1:0] rdata_for(input logic [XLEN-1:0] addr);
        case (addr)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            32'h1F8: return 32'hDEAD;
            default: return {~addr[15:0], addr[15:0]};
        endcase
    endfunction

    // One clock: compare against the scoreboard, advance it, then drive the memory response.
    task automatic cycle();
        logic exp_valid, exp_ready, exp_acc, deq;
        @(negedge clk);
        exp_valid = (model_q.size() != 0);
        check("id_valid", bus.o_id_valid, exp_valid);
        if (exp_valid) begin
            check("id_instr", bus.o_id_instr, model_q[0].instr);
            check("id_pc", bus.o_id_pc, model_q[0].pc);
        end
        check("count", bus.o_count, model_q.size());
        exp_ready = rstn && !bus.i_flush && ((model_q.size() + int'(pend_v)) < DEPTH);
        check("pc_ready", bus.o_pc_ready, exp_ready);
        exp_acc = exp_ready & bus.i_pc_valid;
        check("im_ren", bus.o_im_ren, exp_acc);
        if (exp_acc) check("im_raddr", bus.o_im_raddr, bus.i_pc_data);
        if (bus.o_pc_ready && bus.i_pc_valid) acc_seen++;
        deq = exp_valid & bus.i_id_ready;
        if (!rstn || bus.i_flush) begin
            model_q.delete();
            pend_v = 1'b0;
        end else begin
            if (deq) void'(model_q.pop_front());
            if (pend_v) model_q.push_back(entry_t'{pc: pend_pc, instr: rdata_for(pend_pc)});
            pend_v  = exp_acc;
            pend_pc = bus.i_pc_data;
        end
        @(posedge clk);
        #1;
        bus.i_im_rdata = pend_v ? rdata_for(pend_pc) : 32'hBAD0_BAD0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, bus.o_id_valid, 0);
        check({tag, "_instr"}, bus.o_id_instr, 0);
        check({tag, "_pc"}, bus.o_id_pc, 0);
        check({tag, "_count"}, bus.o_count, 0);
        check({tag, "_ren"}, bus.o_im_ren, 0);
        check({tag, "_ready"}, bus.o_pc_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [XLEN-1:0] pc;
        int              acc_before;

        bus.i_pc_valid = 1'b1;
        bus.i_pc_data  = 32'h0;
        bus.i_im_rdata = 32'hBAD0_BAD0;
        bus.i_flush    = 1'b0;
        bus.i_id_ready = 1'b0;
        #1;
        check_all_zero("reset");
        bus.i_pc_valid = 1'b0;
        cycle();
        cycle();
        rstn = 1'b1;

        // 1: back-to-back PCs 0,4,8 with decode always ready
        bus.i_id_ready = 1'b1;
        bus.i_pc_valid = 1'b1;
        bus.i_pc_data  = 32'h0;
        cycle();
        check("t1_lat_n1", bus.o_id_valid, 0);
        bus.i_pc_data = 32'h4;
        cycle();
        check("t1_v0", bus.o_id_valid, 1);
        check("t1_i0", bus.o_id_instr, 32'h11);
        check("t1_p0", bus.o_id_pc, 32'h0);
        bus.i_pc_data = 32'h8;
        cycle();
        check("t1_i1", bus.o_id_instr, 32'h22);
        check("t1_p1", bus.o_id_pc, 32'h4);
        check("t1_c1", bus.o_count, 1);
        bus.i_pc_valid = 1'b0;
        cycle();
        check("t1_i2", bus.o_id_instr, 32'h33);
        check("t1_p2", bus.o_id_pc, 32'h8);
        check("t1_c2", bus.o_count, 1);
        cycle();
        check("t1_empty", bus.o_id_valid, 0);

        // 2: decode stalled, PCs offered every cycle -> exactly DEPTH accepts
        bus.i_id_ready = 1'b0;
        bus.i_pc_valid = 1'b1;
        pc = 32'h100;
        acc_before = acc_seen;
        for (int i = 0; i < 8; i++) begin
            bus.i_pc_data = pc;
            acc_before = acc_before;
            cycle();
            if (acc_seen != acc_before + ((pc - 32'h100) >> 2)) pc = pc + 32'h4;
        end
        bus.i_pc_data = pc;
        check("t2_accepts", acc_seen - acc_before, 4);
        check("t2_count", bus.o_count, 4);
        check("t2_ready", bus.o_pc_ready, 0);
        check("t2_head_i", bus.o_id_instr, 32'hFEFF_0100);
        check("t2_head_p", bus.o_id_pc, 32'h100);

        // 3: one-cycle dequeue pulse on a full queue; ready rises a cycle later
        bus.i_id_ready = 1'b1;
        #1;
        check("t3_ready_same", bus.o_pc_ready, 0);
        cycle();
        bus.i_id_ready = 1'b0;
        #1;
        check("t3_count", bus.o_count, 3);
        check("t3_ready_next", bus.o_pc_ready, 1);
        bus.i_id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            acc_before = acc_seen;
            cycle();
            if (acc_seen != acc_before) pc = pc + 32'h4;
            bus.i_pc_data = pc;
        end
        bus.i_pc_valid = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("t3_drained", bus.o_count, 0);

        // 4: two queued plus one in flight, then flush
        bus.i_id_ready = 1'b0;
        bus.i_pc_valid = 1'b1;
        bus.i_pc_data  = 32'h1F0;
        cycle();
        bus.i_pc_data = 32'h1F4;
        cycle();
        bus.i_pc_data = 32'h1F8;
        cycle();
        check("t4_pre_count", bus.o_count, 2);
        bus.i_pc_valid = 1'b0;
        bus.i_flush    = 1'b1;
        #1;
        check("t4_flush_ready", bus.o_pc_ready, 0);
        cycle();
        bus.i_flush = 1'b0;
        check("t4_post_valid", bus.o_id_valid, 0);
        check("t4_post_count", bus.o_count, 0);
        bus.i_pc_valid = 1'b1;
        bus.i_pc_data  = 32'h200;
        cycle();
        bus.i_pc_valid = 1'b0;
        cycle();
        check("t4_new_valid", bus.o_id_valid, 1);
        check("t4_new_pc", bus.o_id_pc, 32'h200);
        check("t4_new_instr", bus.o_id_instr, 32'hFDFF_0200);
        cycle();
        check("t4_alone", bus.o_count, 1);
        bus.i_id_ready = 1'b1;
        cycle();
        check("t4_done", bus.o_count, 0);

        // 5: asynchronous reset between edges
        bus.i_pc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.i_pc_data = 32'h80 + 32'(i * 4);
            cycle();
        end
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("areset");
        model_q.delete();
        pend_v = 1'b0;
        bus.i_pc_valid = 1'b0;
        cycle();
        cycle();
        rstn = 1'b1;
        bus.i_pc_valid = 1'b1;
        bus.i_pc_data  = 32'h40;
        bus.i_id_ready = 1'b0;
        cycle();
        bus.i_pc_valid = 1'b0;
        cycle();
        check("t5_valid", bus.o_id_valid, 1);
        check("t5_pc", bus.o_id_pc, 32'h40);
        check("t5_instr", bus.o_id_instr, 32'hFFBF_0040);
        bus.i_id_ready = 1'b1;
        cycle();

        // 6: random valid/ready/flush traffic against the scoreboard
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            bus.i_pc_valid = ($urandom_range(0, 9) < 7);
            bus.i_id_ready = ($urandom_range(0, 9) < 6);
            bus.i_flush    = ($urandom_range(0, 19) == 0);
            bus.i_pc_data  = pc;
            acc_before = acc_seen;
            cycle();
            if (bus.i_flush) pc = 32'h2000 + (32'($urandom_range(0, 63)) << 2);
            else if (acc_seen != acc_before) pc = pc + 32'h4;
        end
        bus.i_pc_valid = 1'b0;
        bus.i_flush    = 1'b0;
        bus.i_id_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        check("t6_drained", bus.o_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
